// File: rtl/mem_datos_pkg.sv
// mem_datos_pkg
// Shared types and constants for the data-memory arbiter:
//   - state_e      : access sequencer states (IDLE / ACCESS / RESP)
//   - WE_*         : write-enable encodings understood by the data memory
//   - MD_*_DEFAULT : default memory window (base address and depth)
//   - PORT_*       : requester ids used for grants and the latched winner
//   - addr_in_range: unsigned window check used before an access is issued
package mem_datos_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_BYTE = 2'b10;
    localparam logic [1:0] WE_ILL  = 2'b11;

    localparam logic [31:0] MD_BASE_ADDR_DEFAULT = 32'hFFFF_0000;
    localparam int unsigned MD_DEPTH_DEFAULT     = 32'd65536;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Window check done in 33 bits so base+depth-1 can reach 0xFFFFFFFF
    // without wrapping.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] depth);
        logic [32:0] lo_v;
        logic [32:0] hi_v;
        lo_v = {1'b0, base};
        hi_v = lo_v + depth - 33'd1;
        return ({1'b0, addr} >= lo_v) && ({1'b0, addr} <= hi_v);
    endfunction

endpackage

// File: rtl/mem_datos_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester round-robin picker. Holds the id of the last granted port
// and hands a simultaneous request to the other one.
// Ports:
//   CLK    : clock, rising edge
//   RST    : synchronous active-low reset (last grant returns to DMA)
//   req    : request vector, bit PORT_CPU / bit PORT_DMA
//   update : commit the current grant as the new last grant
//   grant  : one-hot grant (all zero when nobody requests)
module rr_arb2
    import mem_datos_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic       last_grant_r;
    logic [1:0] grant_s;

    // Grant selection: a lone requester always wins, a tie goes away from last_grant
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11: begin
                if (last_grant_r == PORT_DMA) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b10;
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    // Last-grant register, reset to DMA so the CPU wins the first tie
    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_grant_r <= PORT_DMA;
        end else if (update && (grant_s != 2'b00)) begin
            last_grant_r <= grant_s[PORT_DMA] ? PORT_DMA : PORT_CPU;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/mem_datos_arbiter.sv
// mem_datos_arbiter
// Shares the data memory between a CPU load/store port and a DMA/debug port.
// Each access runs IDLE -> ACCESS -> RESP; the winner's fields are latched in
// IDLE so requester-side changes mid-access are ignored. Out-of-window
// addresses and we=11 are answered with err=1 and never drive the memory.
// Ports:
//   CLK, RST                   : clock, synchronous active-low reset
//   cpu_* / dma_*              : req, we, addr, wword, wbyte in; ack, rdata, err out
//   mem_addr/wword/wbyte/we    : memory drive (idle values outside ACCESS)
//   mem_rdata                  : asynchronous memory read data
//   busy                       : high while the sequencer is not IDLE
module mem_datos_arbiter
    import mem_datos_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MD_BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH     = MD_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wword,
    input  logic [7:0]  cpu_wbyte,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic [1:0]  dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wword,
    input  logic [7:0]  dma_wbyte,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wword,
    output logic [7:0]  mem_wbyte,
    output logic [1:0]  mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_e      state_r;
    logic        port_r;
    logic [1:0]  we_r;
    logic        err_r;

    logic        cpu_ack_r;
    logic [31:0] cpu_rdata_r;
    logic        cpu_err_r;
    logic        dma_ack_r;
    logic [31:0] dma_rdata_r;
    logic        dma_err_r;
    logic        busy_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wword_r;
    logic [7:0]  mem_wbyte_r;
    logic [1:0]  mem_we_r;

    logic [1:0]  req_s;
    logic [1:0]  grant_s;
    logic        arb_update_s;
    logic [1:0]  sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wword_s;
    logic [7:0]  sel_wbyte_s;
    logic        sel_err_s;
    logic [31:0] resp_rdata_s;

    assign req_s        = {dma_req, cpu_req};
    assign arb_update_s = (state_r == IDLE) && (req_s != 2'b00);

    rr_arb2 u_rr_arb2 (
        .CLK    (CLK),
        .RST    (RST),
        .req    (req_s),
        .update (arb_update_s),
        .grant  (grant_s)
    );

    // Winner field mux and the reject decision taken before anything is latched
    always_comb begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wword_s = cpu_wword;
        sel_wbyte_s = cpu_wbyte;
        if (grant_s[PORT_DMA]) begin
            sel_we_s    = dma_we;
            sel_addr_s  = dma_addr;
            sel_wword_s = dma_wword;
            sel_wbyte_s = dma_wbyte;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wword_s = cpu_wword;
            sel_wbyte_s = cpu_wbyte;
        end
        sel_err_s = (sel_we_s == WE_ILL) ||
                    !addr_in_range(sel_addr_s, BASE_ADDR, 33'(DEPTH));
    end

    // Response data: memory word for a clean read, zero for writes and errors
    always_comb begin
        resp_rdata_s = 32'h0000_0000;
        if (!err_r && (we_r == WE_NONE)) begin
            resp_rdata_s = mem_rdata;
        end else begin
            resp_rdata_s = 32'h0000_0000;
        end
    end

    // Access sequencer with latched request fields and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= IDLE;
            port_r      <= PORT_CPU;
            we_r        <= WE_NONE;
            err_r       <= 1'b0;
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            cpu_err_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            dma_rdata_r <= 32'h0000_0000;
            dma_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            mem_addr_r  <= BASE_ADDR;
            mem_wword_r <= 32'h0000_0000;
            mem_wbyte_r <= 8'h00;
            mem_we_r    <= WE_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s != 2'b00) begin
                        port_r  <= grant_s[PORT_DMA] ? PORT_DMA : PORT_CPU;
                        we_r    <= sel_we_s;
                        err_r   <= sel_err_s;
                        busy_r  <= 1'b1;
                        state_r <= ACCESS;
                        // The memory drive is loaded here so it is stable for the whole ACCESS cycle
                        if (!sel_err_s) begin
                            mem_addr_r  <= sel_addr_s;
                            mem_wword_r <= sel_wword_s;
                            mem_wbyte_r <= sel_wbyte_s;
                            mem_we_r    <= sel_we_s;
                        end else begin
                            mem_addr_r  <= BASE_ADDR;
                            mem_wword_r <= 32'h0000_0000;
                            mem_wbyte_r <= 8'h00;
                            mem_we_r    <= WE_NONE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (port_r == PORT_DMA) begin
                        dma_ack_r   <= 1'b1;
                        dma_err_r   <= err_r;
                        dma_rdata_r <= resp_rdata_s;
                    end else begin
                        cpu_ack_r   <= 1'b1;
                        cpu_err_r   <= err_r;
                        cpu_rdata_r <= resp_rdata_s;
                    end
                    mem_addr_r  <= BASE_ADDR;
                    mem_wword_r <= 32'h0000_0000;
                    mem_wbyte_r <= 8'h00;
                    mem_we_r    <= WE_NONE;
                    state_r     <= RESP;
                end
                RESP: begin
                    cpu_ack_r   <= 1'b0;
                    cpu_err_r   <= 1'b0;
                    cpu_rdata_r <= 32'h0000_0000;
                    dma_ack_r   <= 1'b0;
                    dma_err_r   <= 1'b0;
                    dma_rdata_r <= 32'h0000_0000;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    cpu_ack_r   <= 1'b0;
                    dma_ack_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    mem_we_r    <= WE_NONE;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign cpu_err   = cpu_err_r;
    assign dma_ack   = dma_ack_r;
    assign dma_rdata = dma_rdata_r;
    assign dma_err   = dma_err_r;
    assign busy      = busy_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wword = mem_wword_r;
    assign mem_wbyte = mem_wbyte_r;
    // Reset low forces the write enable off so a reset edge can never commit a write
    assign mem_we    = RST ? mem_we_r : WE_NONE;

endmodule

// File: tb/tb_mem_datos_arbiter.sv
module tb_mem_datos_arbiter;
    import mem_datos_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cpu_req = 1'b0, dma_req = 1'b0;
    logic [1:0]  cpu_we = 2'b00, dma_we = 2'b00;
    logic [31:0] cpu_addr = 32'h0, dma_addr = 32'h0;
    logic [31:0] cpu_wword = 32'h0, dma_wword = 32'h0;
    logic [7:0]  cpu_wbyte = 8'h0, dma_wbyte = 8'h0;
    logic        cpu_ack, dma_ack, cpu_err, dma_err, busy;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_wword, mem_rdata;
    logic [7:0]  mem_wbyte;
    logic [1:0]  mem_we;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t cpu_q[$];
    exp_t dma_q[$];
    logic ack_order[$];

    mem_datos_arbiter dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wword(cpu_wword), .cpu_wbyte(cpu_wbyte),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wword(dma_wword), .dma_wbyte(dma_wbyte),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_wword(mem_wword), .mem_wbyte(mem_wbyte),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Data memory model: asynchronous read, write on rising edge, byte merge into [7:0]
    logic [31:0] mem [0:65535];
    logic [31:0] midx;
    assign midx      = mem_addr - BASE;
    assign mem_rdata = (midx < 32'd65536) ? mem[midx[15:0]] : 32'h0;

    always @(posedge CLK) begin
        if (mem_we != 2'b00 && midx < 32'd65536) begin
            if (mem_we == 2'b01) mem[midx[15:0]] <= mem_wword;
            else if (mem_we == 2'b10) mem[midx[15:0]][7:0] <= mem_wbyte;
        end
    end

    always @(posedge CLK) begin
        if (mem_we != 2'b00) wr_cnt <= wr_cnt + 1;
    end

    // One access on one port; expected response queued on drive, popped on ack
    task automatic access(input logic port, input logic [1:0] we, input logic [31:0] addr,
                          input logic [31:0] wword, input logic [7:0] wbyte,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input bit scramble, input string name);
        exp_t e;
        int   n;
        bit   got;
        logic [31:0] rd;
        logic er;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (port == PORT_CPU) begin
            cpu_q.push_back(e);
            cpu_we = we; cpu_addr = addr; cpu_wword = wword; cpu_wbyte = wbyte; cpu_req = 1'b1;
        end else begin
            dma_q.push_back(e);
            dma_we = we; dma_addr = addr; dma_wword = wword; dma_wbyte = wbyte; dma_req = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(posedge CLK);
            #1;
            n++;
            if ((port == PORT_CPU) ? cpu_ack : dma_ack) got = 1'b1;
            else if (scramble && n == 1) begin
                if (port == PORT_CPU) begin
                    cpu_addr = addr ^ 32'h0000_0008; cpu_wword = ~wword;
                end else begin
                    dma_addr = addr ^ 32'h0000_0008; dma_wword = ~wword;
                end
            end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s: no ack within 30 cycles", name);
            if (port == PORT_CPU) void'(cpu_q.pop_front()); else void'(dma_q.pop_front());
        end else begin
            if (port == PORT_CPU) begin
                e = cpu_q.pop_front(); rd = cpu_rdata; er = cpu_err;
            end else begin
                e = dma_q.pop_front(); rd = dma_rdata; er = dma_err;
            end
            ack_order.push_back(port);
            if (rd !== e.rdata || er !== e.err) begin
                tests_failed++;
                $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b",
                         name, rd, er, e.rdata, e.err);
            end
            if (exp_lat > 0) begin
                tests_run++;
                if (n !== exp_lat) begin
                    tests_failed++;
                    $display("FAIL %s_latency: got %0d cycles, want %0d", name, n, exp_lat);
                end
            end
        end
        if (port == PORT_CPU) begin
            cpu_req = 1'b0; cpu_we = 2'b00; cpu_addr = 32'h0; cpu_wword = 32'h0; cpu_wbyte = 8'h0;
        end else begin
            dma_req = 1'b0; dma_we = 2'b00; dma_addr = 32'h0; dma_wword = 32'h0; dma_wbyte = 8'h0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [142:0] got_v;
        logic [142:0] want_v;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        want_v = {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, BASE, 32'h0, 8'h00};
        got_v  = {cpu_ack, cpu_err, cpu_rdata, dma_ack, dma_err, dma_rdata,
                  busy, mem_we, mem_addr, mem_wword, mem_wbyte};
        tests_run++;
        if (got_v !== want_v) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, want %h", got_v, want_v);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++;
        if (busy !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b acks=%b%b, want 0 00", busy, cpu_ack, dma_ack);
        end
    endtask

    task automatic test_word_rw();
        access(PORT_CPU, WE_WORD, 32'hFFFF_0004, 32'hDEAD_BEEF, 8'h00, 32'h0, 1'b0, 2, 1'b0, "cpu_word_write");
        access(PORT_CPU, WE_NONE, 32'hFFFF_0004, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, "cpu_word_read");
    endtask

    task automatic test_round_robin();
        logic want_v [$];
        test_reset();
        ack_order.delete();
        for (int r = 0; r < 3; r++) begin
            fork
                access(PORT_CPU, WE_WORD, 32'hFFFF_0100 + 32'(r), 32'h1000 + 32'(r), 8'h00, 32'h0, 1'b0, 2, 1'b0, "rr_cpu");
                access(PORT_DMA, WE_WORD, 32'hFFFF_0200 + 32'(r), 32'h2000 + 32'(r), 8'h00, 32'h0, 1'b0, 5, 1'b0, "rr_dma");
            join
        end
        access(PORT_CPU, WE_NONE, 32'hFFFF_0101, 32'h0, 8'h00, 32'h0000_1001, 1'b0, 2, 1'b0, "rr_cpu_solo");
        fork
            access(PORT_CPU, WE_NONE, 32'hFFFF_0102, 32'h0, 8'h00, 32'h0000_1002, 1'b0, 5, 1'b0, "rr_cpu_after_solo");
            access(PORT_DMA, WE_NONE, 32'hFFFF_0202, 32'h0, 8'h00, 32'h0000_2002, 1'b0, 2, 1'b0, "rr_dma_after_solo");
        join
        want_v = '{PORT_CPU, PORT_DMA, PORT_CPU, PORT_DMA, PORT_CPU, PORT_DMA,
                   PORT_CPU, PORT_DMA, PORT_CPU};
        tests_run++;
        if (ack_order != want_v) begin
            tests_failed++;
            $display("FAIL rr_order: got %p, want %p", ack_order, want_v);
        end
    endtask

    task automatic test_byte_write();
        access(PORT_DMA, WE_WORD, 32'hFFFF_0020, 32'h1122_3344, 8'h00, 32'h0, 1'b0, 2, 1'b0, "dma_word_write");
        access(PORT_DMA, WE_BYTE, 32'hFFFF_0020, 32'h0, 8'h5A, 32'h0, 1'b0, 2, 1'b0, "dma_byte_write");
        access(PORT_DMA, WE_NONE, 32'hFFFF_0020, 32'h0, 8'h00, 32'h1122_335A, 1'b0, 2, 1'b0, "dma_byte_read");
    endtask

    task automatic test_errors();
        int w0;
        access(PORT_CPU, WE_WORD, 32'hFFFF_0000, 32'hA5A5_A5A5, 8'h00, 32'h0, 1'b0, 2, 1'b0, "err_setup");
        w0 = wr_cnt;
        access(PORT_CPU, WE_WORD, 32'h0000_1000, 32'hFFFF_FFFF, 8'h00, 32'h0, 1'b1, 2, 1'b0, "err_low_addr");
        access(PORT_CPU, WE_ILL, 32'hFFFF_0000, 32'h0BAD_0BAD, 8'hEE, 32'h0, 1'b1, 2, 1'b0, "err_illegal_we");
        access(PORT_DMA, WE_NONE, 32'hFFFE_FFFF, 32'h0, 8'h00, 32'h0, 1'b1, 2, 1'b0, "err_below_base");
        tests_run++;
        if (wr_cnt !== w0) begin
            tests_failed++;
            $display("FAIL err_no_write: got %0d write cycles, want 0", wr_cnt - w0);
        end
        access(PORT_CPU, WE_NONE, 32'hFFFF_0000, 32'h0, 8'h00, 32'hA5A5_A5A5, 1'b0, 2, 1'b0, "err_mem_intact");
    endtask

    task automatic test_reset_abort();
        int   w0;
        bit   saw_ack;
        logic [142:0] got_v;
        logic [142:0] want_v;
        access(PORT_CPU, WE_WORD, 32'hFFFF_0010, 32'h0BAD_C0DE, 8'h00, 32'h0, 1'b0, 2, 1'b0, "abort_setup");
        w0 = wr_cnt;
        cpu_we = WE_WORD; cpu_addr = 32'hFFFF_0010; cpu_wword = 32'hCAFE_F00D; cpu_req = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_in_access: got busy=%b, want 1", busy);
        end
        RST = 1'b0;
        cpu_req = 1'b0; cpu_we = 2'b00; cpu_addr = 32'h0; cpu_wword = 32'h0;
        @(posedge CLK);
        #1;
        want_v = {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, BASE, 32'h0, 8'h00};
        got_v  = {cpu_ack, cpu_err, cpu_rdata, dma_ack, dma_err, dma_rdata,
                  busy, mem_we, mem_addr, mem_wword, mem_wbyte};
        tests_run++;
        if (got_v !== want_v) begin
            tests_failed++;
            $display("FAIL abort_outputs: got %h, want %h", got_v, want_v);
        end
        RST = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            if (cpu_ack || dma_ack || busy) saw_ack = 1'b1;
        end
        tests_run++;
        if (saw_ack !== 1'b0 || wr_cnt !== w0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got ack_or_busy=%b writes=%0d, want 0 0", saw_ack, wr_cnt - w0);
        end
        access(PORT_CPU, WE_NONE, 32'hFFFF_0010, 32'h0, 8'h00, 32'h0BAD_C0DE, 1'b0, 2, 1'b0, "abort_mem_intact");
    endtask

    task automatic test_boundary();
        access(PORT_CPU, WE_WORD, 32'hFFFF_FFFF, 32'h1234_5678, 8'h00, 32'h0, 1'b0, 2, 1'b0, "top_write");
        access(PORT_DMA, WE_NONE, 32'hFFFF_FFFF, 32'h0, 8'h00, 32'h1234_5678, 1'b0, 2, 1'b0, "top_read");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_round_robin();
        test_byte_write();
        test_errors();
        test_reset_abort();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
